velocity_digit_converter: RTL and testbench
===========================================

VELOCITY_DIGIT_CONVERTER -- requirements
Module: velocity_digit_converter

Interface
REQ-001 SHALL have parameter SPEED_SHIFT, default 2, the right-shift applied to the raw speed magnitude before display.
REQ-002 SHALL have parameter SPEED_W, default VELOCITY_OUTPUT_WIDTH+1 (8), the width of the displayed speed value.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, the reset, which is synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1, a request to convert the current velocity sample.
REQ-006 SHALL have port i_vel_x, input, VELOCITY_INTEGER_WIDTH+VELOCITY_FRACTION_WIDTH (10), the signed x velocity in Q4.6 two's complement.
REQ-007 SHALL have port i_vel_y, input, 10, the signed y velocity in Q4.6 two's complement.
REQ-008 SHALL have port o_busy, output, 1, asserted while a conversion is in progress.
REQ-009 SHALL have port o_valid, output, 1, a one-cycle pulse indicating that new digits are available.
REQ-010 SHALL have port o_speed, output, SPEED_W, the scaled speed magnitude.
REQ-011 SHALL have ports o_digit_hundred, o_digit_ten and o_digit_one, output, 4 each, the BCD digits in VelocityDisplayDigit order; code 4'hF means blank, which selects VELOCITY_DISPLAY_BG.

Function
REQ-012 SHALL implement the FSM states IDLE, MAG, CONV and DONE; o_busy = (state != IDLE).
REQ-013 SHALL, in IDLE with i_start=1, latch i_vel_x and i_vel_y and go to MAG; i_start SHALL be ignored in every other state, with no queuing.
REQ-014 SHALL, in MAG, compute for one cycle: ax=|vx| and ay=|vy| as 10-bit unsigned (|-512|=512); mag = max(ax,ay) + (min(ax,ay)>>1) as 11-bit unsigned; speed = mag >> SPEED_SHIFT, truncated toward zero.
REQ-015 SHALL, at the end of MAG, register speed into o_speed (saturating to 2^SPEED_W-1 if it would overflow), clear the BCD shift register, set bit counter = 0 and go to CONV.
REQ-016 SHALL, in CONV, perform one serial double-dabble step per cycle: add 3 to each BCD nibble that is >=5, then shift left one bit, taking in the speed bit MSB-first; this runs for exactly SPEED_W cycles.
REQ-017 SHALL, after the last CONV cycle, load the digit outputs from the BCD register (applying REQ-024 if enabled) and go to DONE.
REQ-018 SHALL assert o_valid only in DONE, then go to IDLE the next cycle.
REQ-019 SHALL produce this latency: start sampled at edge E -> o_valid high in the cycle after edge E+SPEED_W+1 (E+9 at default) -> o_busy low after edge E+SPEED_W+2.
REQ-020 SHALL allow back-to-back use: i_start asserted in the first IDLE cycle after DONE is accepted.
REQ-021 SHALL hold o_speed and the digit outputs stable between updates; they change only at the MAG exit (o_speed) and the CONV exit (digits).
REQ-022 SHALL always keep each digit in the range 0..9 or 4'hF; hundreds <= 1 at default parameters (max speed 192).

Reset
REQ-023 SHALL, while i_rst=1 at an edge, set state=IDLE, o_busy=0, o_valid=0, o_speed=0, all digits=0 (or the blanked form 4'hF, 4'hF, 0 per REQ-024), counter=0 and BCD register=0; reset SHALL override i_start and SHALL abort an in-progress conversion with no o_valid issued.

Configuration
REQ-024 SHALL, when VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN is defined, replace a zero hundreds digit with 4'hF, and a zero tens digit with 4'hF when hundreds is also blank; the ones digit is never blanked. When the macro is undefined, digits are output as plain BCD and no blanking logic exists.

Verification
REQ-025 SHALL cover: vx=0x0E0 (+3.5), vy=0, start -> o_valid at E+9, o_speed=56, digits 0,5,6 (blank build: F,5,6).
REQ-026 SHALL cover: vx=-512, vy=-512 -> o_speed=192, digits 1,9,2.
REQ-027 SHALL cover: vx=-160, vy=+96 -> mag=208, o_speed=52, digits 0,5,2; and vx=3, vy=0 -> o_speed=0, digits 0,0,0 (blank build: F,F,0).
REQ-028 SHALL cover: i_start pulsed again at E+3 while busy -> ignored, exactly one o_valid, results from the first sample.
REQ-029 SHALL cover: i_rst asserted at E+5 mid-CONV -> next cycle state IDLE, o_busy=0, digits at reset values, no o_valid; a new start then completes normally.

Source files
------------

// File: rtl/velocity_digit_converter.sv
//==============================================================================
// Module      : velocity_digit_converter
// Description : Converts a Q4.6 (x,y) velocity sample into a scaled speed
//               magnitude and three BCD display digits via serial double-dabble.
//               Optional macro VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN blanks
//               leading zero digits (code 4'hF).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module velocity_digit_converter #(
    parameter int SPEED_SHIFT = 2,
    parameter int SPEED_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [9:0]         i_vel_x,
    input  logic [9:0]         i_vel_y,
    output logic               o_busy,
    output logic               o_valid,
    output logic [SPEED_W-1:0] o_speed,
    output logic [3:0]         o_digit_hundred,
    output logic [3:0]         o_digit_ten,
    output logic [3:0]         o_digit_one
);

    localparam int         C_VEL_W = 10;
    localparam int         C_MAG_W = C_VEL_W + 1;
    localparam int         C_CNT_W = $clog2(SPEED_W + 1);
    localparam logic [3:0] C_BLANK = 4'hF;

`ifdef VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] C_RST_HUNDRED = C_BLANK;
    localparam logic [3:0] C_RST_TEN     = C_BLANK;
`else
    localparam logic [3:0] C_RST_HUNDRED = 4'd0;
    localparam logic [3:0] C_RST_TEN     = 4'd0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAG  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_valid;
    logic [C_VEL_W-1:0]   r_vx;
    logic [C_VEL_W-1:0]   r_vy;
    logic [SPEED_W-1:0]   r_speed;
    logic [SPEED_W-1:0]   r_shift;
    logic [11:0]          r_bcd;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_dig_hundred;
    logic [3:0]           r_dig_ten;
    logic [3:0]           r_dig_one;

    logic [C_VEL_W-1:0]   w_ax;
    logic [C_VEL_W-1:0]   w_ay;
    logic [C_VEL_W-1:0]   w_max;
    logic [C_VEL_W-1:0]   w_min;
    logic [C_MAG_W-1:0]   w_mag;
    logic [C_MAG_W-1:0]   w_speed_full;
    logic [SPEED_W-1:0]   w_speed;
    logic [3:0]           w_one_adj;
    logic [3:0]           w_ten_adj;
    logic [2:0]           w_hun_adj;
    logic [11:0]          w_bcd_next;
    logic [3:0]           w_dig_hundred;
    logic [3:0]           w_dig_ten;
    logic [3:0]           w_dig_one;
    logic                 w_last;

    // Two's-complement negation keeps |-512| = 512 when read as unsigned.
    assign w_ax         = r_vx[C_VEL_W-1] ? (~r_vx + 1'b1) : r_vx;
    assign w_ay         = r_vy[C_VEL_W-1] ? (~r_vy + 1'b1) : r_vy;
    assign w_max        = (w_ax >= w_ay) ? w_ax : w_ay;
    assign w_min        = (w_ax >= w_ay) ? w_ay : w_ax;
    assign w_mag        = {1'b0, w_max} + C_MAG_W'(w_min >> 1);
    assign w_speed_full = w_mag >> SPEED_SHIFT;

    generate
        if (SPEED_W >= C_MAG_W) begin : g_no_sat
            assign w_speed = SPEED_W'(w_speed_full);
        end else begin : g_sat
            assign w_speed = (|w_speed_full[C_MAG_W-1:SPEED_W]) ? {SPEED_W{1'b1}}
                                                                : w_speed_full[SPEED_W-1:0];
        end
    endgenerate

    // Only the low three bits of the hundreds nibble survive the shift.
    assign w_one_adj  = (r_bcd[3:0]  >= 4'd5) ? (r_bcd[3:0]  + 4'd3) : r_bcd[3:0];
    assign w_ten_adj  = (r_bcd[7:4]  >= 4'd5) ? (r_bcd[7:4]  + 4'd3) : r_bcd[7:4];
    assign w_hun_adj  = (r_bcd[11:8] >= 4'd5) ? 3'(r_bcd[11:8] + 4'd3) : r_bcd[10:8];
    assign w_bcd_next = {w_hun_adj, w_ten_adj, w_one_adj, r_shift[SPEED_W-1]};
    assign w_last     = (r_cnt == C_CNT_W'(SPEED_W - 1));

    assign w_dig_one  = w_bcd_next[3:0];
`ifdef VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN
    assign w_dig_hundred = (w_bcd_next[11:8] == 4'd0) ? C_BLANK : w_bcd_next[11:8];
    assign w_dig_ten     = ((w_bcd_next[11:8] == 4'd0) && (w_bcd_next[7:4] == 4'd0))
                           ? C_BLANK : w_bcd_next[7:4];
`else
    assign w_dig_hundred = w_bcd_next[11:8];
    assign w_dig_ten     = w_bcd_next[7:4];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_vx          <= '0;
            r_vy          <= '0;
            r_speed       <= '0;
            r_shift       <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_dig_hundred <= C_RST_HUNDRED;
            r_dig_ten     <= C_RST_TEN;
            r_dig_one     <= 4'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_vx    <= i_vel_x;
                        r_vy    <= i_vel_y;
                        r_busy  <= 1'b1;
                        r_state <= MAG;
                    end
                end
                MAG: begin
                    r_speed <= w_speed;
                    r_shift <= w_speed;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= CONV;
                end
                CONV: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_dig_hundred <= w_dig_hundred;
                        r_dig_ten     <= w_dig_ten;
                        r_dig_one     <= w_dig_one;
                        r_valid       <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_valid         = r_valid;
    assign o_speed         = r_speed;
    assign o_digit_hundred = r_dig_hundred;
    assign o_digit_ten     = r_dig_ten;
    assign o_digit_one     = r_dig_one;

endmodule

`default_nettype wire

// File: tb/tb_velocity_digit_converter.sv
//==============================================================================
// Module      : tb_velocity_digit_converter
// Description : Directed self-checking bench for velocity_digit_converter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_velocity_digit_converter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] vel_x;
    logic [9:0] vel_y;
    logic       busy;
    logic       valid;
    logic [7:0] speed;
    logic [3:0] dig_h;
    logic [3:0] dig_t;
    logic [3:0] dig_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] prev_h;

    velocity_digit_converter #(
        .SPEED_SHIFT (2),
        .SPEED_W     (8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_vel_x         (vel_x),
        .i_vel_y         (vel_y),
        .o_busy          (busy),
        .o_valid         (valid),
        .o_speed         (speed),
        .o_digit_hundred (dig_h),
        .o_digit_ten     (dig_t),
        .o_digit_one     (dig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [3:0] exp_hun(input logic [3:0] h);
`ifdef VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN
        return (h == 4'd0) ? 4'hF : h;
`else
        return h;
`endif
    endfunction

    function automatic logic [3:0] exp_ten(input logic [3:0] h, input logic [3:0] t);
`ifdef VELOCITY_DIGIT_LEADING_ZERO_BLANK_EN
        return ((h == 4'd0) && (t == 4'd0)) ? 4'hF : t;
`else
        return t;
`endif
    endfunction

    // Caller is at a negedge; start is sampled at the next posedge (edge E).
    task automatic do_conv(input string tag, input logic [9:0] vx, input logic [9:0] vy,
                           input logic [7:0] spd, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, input int restart_n);
        int n;
        vel_x = vx;
        vel_y = vy;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        vel_x = 10'h000;
        vel_y = 10'h000;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!valid && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check({tag, "_speed_early"}, 32'(speed), 32'(spd));
            if (n == 4) check({tag, "_hold_hun"}, 32'(dig_h), 32'(prev_h));
            if (restart_n > 0 && n == restart_n - 1) begin
                start = 1'b1;
                vel_x = 10'h200;
                vel_y = 10'h200;
            end
            if (restart_n > 0 && n == restart_n) begin
                start = 1'b0;
                vel_x = 10'h000;
                vel_y = 10'h000;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_speed"}, 32'(speed), 32'(spd));
        check({tag, "_hun"}, 32'(dig_h), 32'(exp_hun(h)));
        check({tag, "_ten"}, 32'(dig_t), 32'(exp_ten(h, t)));
        check({tag, "_one"}, 32'(dig_o), 32'(o));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        prev_h = exp_hun(h);
    endtask

    task automatic watch_valid(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) cnt++;
        end
        check({tag, "_extra_valid"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        vel_x = 10'h000;
        vel_y = 10'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_speed", 32'(speed), 32'd0);
        check("rst_hun", 32'(dig_h), 32'(exp_hun(4'd0)));
        check("rst_ten", 32'(dig_t), 32'(exp_ten(4'd0, 4'd0)));
        check("rst_one", 32'(dig_o), 32'd0);
        // Start held during reset must be ignored.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rst_ovr_busy", 32'(busy), 32'd0);
        rst    = 1'b0;
        prev_h = exp_hun(4'd0);
        @(negedge clk);

        do_conv("p3_5", 10'h0E0, 10'h000, 8'd56, 4'd0, 4'd5, 4'd6, 0);
        do_conv("neg512", 10'h200, 10'h200, 8'd192, 4'd1, 4'd9, 4'd2, 0);
        do_conv("mixed", 10'h360, 10'h060, 8'd52, 4'd0, 4'd5, 4'd2, 0);
        do_conv("tiny", 10'h003, 10'h000, 8'd0, 4'd0, 4'd0, 4'd0, 0);
        do_conv("max511", 10'h1FF, 10'h3FF, 8'd127, 4'd1, 4'd2, 4'd7, 0);

        repeat (2) @(negedge clk);
        do_conv("restart", 10'h0E0, 10'h000, 8'd56, 4'd0, 4'd5, 4'd6, 3);
        watch_valid("restart", 12);
        check("restart_busy", 32'(busy), 32'd0);

        // Abort mid-conversion: reset sampled at edge E+5.
        vel_x = 10'h200;
        vel_y = 10'h200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_speed", 32'(speed), 32'd0);
        check("abort_hun", 32'(dig_h), 32'(exp_hun(4'd0)));
        check("abort_ten", 32'(dig_t), 32'(exp_ten(4'd0, 4'd0)));
        check("abort_one", 32'(dig_o), 32'd0);
        watch_valid("abort", 12);
        prev_h = exp_hun(4'd0);
        do_conv("post_abort", 10'h360, 10'h060, 8'd52, 4'd0, 4'd5, 4'd2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
